// File: rtl/avalon_streaming_fifo.sv
// Avalon-ST sink-to-source FIFO with packet framing, fill level and optional
// store-and-forward release. Ready latency 0 on both sides.
module avalon_streaming_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 10,
  parameter int PACKET_MODE = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           asi_valid,
  input  logic [DATA_WIDTH-1:0]          asi_data,
  input  logic                           asi_startofpacket,
  input  logic                           asi_endofpacket,
  output logic                           asi_ready,
  output logic                           aso_valid,
  output logic [DATA_WIDTH-1:0]          aso_data,
  output logic                           aso_startofpacket,
  output logic                           aso_endofpacket,
  input  logic                           aso_ready,
  output logic [$clog2(DEPTH+1)-1:0]     fill_level
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = DATA_WIDTH + 2;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic [CW-1:0] pkt_cnt;
  logic [EW-1:0] head;
  logic          push, pop;
  logic          push_eop, pop_eop;

  assign head     = mem[rd_ptr];
  assign push     = asi_valid && asi_ready;
  assign pop      = aso_valid && aso_ready;
  assign push_eop = push && asi_endofpacket;
  assign pop_eop  = pop && head[0];

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (!push && pop)
      count_next = count - 1'b1;
  end

  // In store-and-forward mode a full buffer releases data anyway so that a
  // packet longer than DEPTH still drains.
  always_comb begin
    aso_valid = (count != '0);
    if (PACKET_MODE != 0)
      aso_valid = (count != '0) && ((pkt_cnt != '0) || (count == CW'(DEPTH)));
  end

  assign aso_data          = head[EW-1:2];
  assign aso_startofpacket = aso_valid && head[1];
  assign aso_endofpacket   = aso_valid && head[0];
  assign fill_level        = count;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {asi_data, asi_startofpacket, asi_endofpacket};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pkt_cnt   <= '0;
      asi_ready <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count_next;
      if (push_eop && !pop_eop)
        pkt_cnt <= pkt_cnt + 1'b1;
      else if (!push_eop && pop_eop)
        pkt_cnt <= pkt_cnt - 1'b1;
      asi_ready <= (count_next < CW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_avalon_streaming_fifo.sv
// Bench for avalon_streaming_fifo: a cut-through and a store-and-forward
// instance share stimulus; per-instance scoreboards check output word order.
module tb_avalon_streaming_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       asi_valid = 1'b0;
  logic [7:0] asi_data = '0;
  logic       asi_sop = 1'b0;
  logic       asi_eop = 1'b0;
  logic       aso_ready = 1'b0;

  logic       rdy0, v0, s0, e0, rdy1, v1, s1, e1;
  logic [7:0] d0, d1;
  logic [3:0] fl0, fl1;

  int errors = 0;
  int checks = 0;
  logic [9:0] q0[$];
  logic [9:0] q1[$];

  always #5 clk = ~clk;

  avalon_streaming_fifo #(.DATA_WIDTH(8), .DEPTH(10), .PACKET_MODE(0)) u0 (
    .clk(clk), .reset(reset), .asi_valid(asi_valid), .asi_data(asi_data),
    .asi_startofpacket(asi_sop), .asi_endofpacket(asi_eop), .asi_ready(rdy0),
    .aso_valid(v0), .aso_data(d0), .aso_startofpacket(s0), .aso_endofpacket(e0),
    .aso_ready(aso_ready), .fill_level(fl0));

  avalon_streaming_fifo #(.DATA_WIDTH(8), .DEPTH(10), .PACKET_MODE(1)) u1 (
    .clk(clk), .reset(reset), .asi_valid(asi_valid), .asi_data(asi_data),
    .asi_startofpacket(asi_sop), .asi_endofpacket(asi_eop), .asi_ready(rdy1),
    .aso_valid(v1), .aso_data(d1), .aso_startofpacket(s1), .aso_endofpacket(e1),
    .aso_ready(aso_ready), .fill_level(fl1));

  // Scoreboards: accepted input words are queued, accepted output words are
  // compared against the queue head (pop before push: same-cycle push cannot
  // be the word being popped).
  always @(negedge clk) begin
    logic [9:0] exp;
    if (reset) begin
      if (v0 && aso_ready) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL sb0_underflow got=%h expected none", {s0, e0, d0});
        end else begin
          exp = q0.pop_front();
          if ({s0, e0, d0} !== exp) begin
            errors++;
            $display("FAIL sb0_word got=%h expected=%h", {s0, e0, d0}, exp);
          end
        end
      end
      if (asi_valid && rdy0) q0.push_back({asi_sop, asi_eop, asi_data});
      if (v1 && aso_ready) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL sb1_underflow got=%h expected none", {s1, e1, d1});
        end else begin
          exp = q1.pop_front();
          if ({s1, e1, d1} !== exp) begin
            errors++;
            $display("FAIL sb1_word got=%h expected=%h", {s1, e1, d1}, exp);
          end
        end
      end
      if (asi_valid && rdy1) q1.push_back({asi_sop, asi_eop, asi_data});
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next();
    reset = 1'b0; asi_valid = 1'b0; aso_ready = 1'b0; asi_sop = 1'b0; asi_eop = 1'b0;
    next();
    @(negedge clk);
    q0.delete();
    q1.delete();
    next();
    reset = 1'b1;
    next();
  endtask

  task automatic test_reset();
    next();
    next();
    @(negedge clk);
    checks++;
    if ({rdy0, v0, s0, e0} !== 4'b0) begin
      errors++; $display("FAIL rst_outs0 got=%b expected=0000", {rdy0, v0, s0, e0});
    end
    checks++;
    if ({rdy1, v1, s1, e1} !== 4'b0) begin
      errors++; $display("FAIL rst_outs1 got=%b expected=0000", {rdy1, v1, s1, e1});
    end
    checks++;
    if (fl0 !== 4'd0 || fl1 !== 4'd0) begin
      errors++; $display("FAIL rst_fill got=%0d/%0d expected=0", fl0, fl1);
    end
    next();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b0) begin
      errors++; $display("FAIL rst_ready_hold got=%b expected=0", rdy0);
    end
    next();
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
      errors++; $display("FAIL rst_ready_rise got=%b%b expected=11", rdy0, rdy1);
    end
  endtask

  task automatic test_basic();
    logic [7:0] words [3];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    aso_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next();
      asi_valid = 1'b1; asi_data = words[i]; asi_sop = (i == 0); asi_eop = (i == 2);
      @(negedge clk);
      checks++;
      if (v0 !== (i > 0)) begin
        errors++; $display("FAIL basic_valid[%0d] got=%b expected=%b", i, v0, i > 0);
      end
      checks++;
      if (fl0 > 4'd1) begin
        errors++; $display("FAIL basic_fill[%0d] got=%0d expected<=1", i, fl0);
      end
    end
    next();
    asi_valid = 1'b0; asi_sop = 1'b0; asi_eop = 1'b0;
    @(negedge clk);
    checks++;
    if (v0 !== 1'b1 || d0 !== 8'h33 || fl0 !== 4'd1) begin
      errors++; $display("FAIL basic_last got=%b/%h/%0d expected=1/33/1", v0, d0, fl0);
    end
    next();
    @(negedge clk);
    checks++;
    if (v0 !== 1'b0 || fl0 !== 4'd0) begin
      errors++; $display("FAIL basic_empty got=%b/%0d expected=0/0", v0, fl0);
    end
  endtask

  task automatic test_full();
    do_reset();
    aso_ready = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      next();
      asi_valid = 1'b1; asi_data = 8'(i); asi_sop = 1'b0; asi_eop = 1'b0;
      @(negedge clk);
      checks++;
      if (fl0 !== 4'(i) || rdy0 !== (i < 10)) begin
        errors++;
        $display("FAIL full_fill[%0d] got=%0d/%b expected=%0d/%b", i, fl0, rdy0, i, i < 10);
      end
    end
    next();
    asi_valid = 1'b0; aso_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (fl0 !== 4'd10 || v0 !== 1'b1 || d0 !== 8'h00 || fl1 !== 4'd10 || v1 !== 1'b1) begin
      errors++;
      $display("FAIL full_state got=%0d/%b/%h/%0d/%b expected=10/1/00/10/1", fl0, v0, d0, fl1, v1);
    end
    next();
    aso_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (fl0 !== 4'd9 || rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
      errors++; $display("FAIL full_pop got=%0d/%b/%b expected=9/1/1", fl0, rdy0, rdy1);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 20; k++) begin
      next();
      asi_valid = 1'b1; asi_data = 8'(8'h40 + k); aso_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (fl0 !== 4'd9 || rdy0 !== 1'b1 || v0 !== 1'b1) begin
        errors++; $display("FAIL b2b[%0d] got=%0d/%b/%b expected=9/1/1", k, fl0, rdy0, v0);
      end
    end
    next();
    asi_valid = 1'b0;
    for (int k = 0; k < 11; k++) next();
    @(negedge clk);
    checks++;
    if (q0.size() != 0 || v0 !== 1'b0 || fl0 !== 4'd0) begin
      errors++; $display("FAIL b2b_drain got=%0d/%b/%0d expected=0/0/0", q0.size(), v0, fl0);
    end
  endtask

  task automatic test_packet_short();
    do_reset();
    aso_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next();
      asi_valid = 1'b1; asi_data = 8'(8'hC0 + i); asi_sop = (i == 0); asi_eop = (i == 3);
      @(negedge clk);
      checks++;
      if (v1 !== 1'b0) begin
        errors++; $display("FAIL pkt4_hold[%0d] got=%b expected=0", i, v1);
      end
    end
    next();
    asi_valid = 1'b0; asi_sop = 1'b0; asi_eop = 1'b0;
    @(negedge clk);
    checks++;
    if (v1 !== 1'b1 || s1 !== 1'b1 || e1 !== 1'b0 || fl1 !== 4'd4) begin
      errors++; $display("FAIL pkt4_release got=%b/%b/%b/%0d expected=1/1/0/4", v1, s1, e1, fl1);
    end
    for (int j = 0; j < 4; j++) next();
    @(negedge clk);
    checks++;
    if (v1 !== 1'b0 || q1.size() != 0) begin
      errors++; $display("FAIL pkt4_drain got=%b/%0d expected=0/0", v1, q1.size());
    end
  endtask

  task automatic test_packet_long();
    int m = 0, pk = 0, i = 0, o = 0;
    logic rdy = 1'b1, ev, push, pop;
    do_reset();
    aso_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      next();
      asi_valid = (i < 12); asi_data = 8'(8'h80 + i); asi_sop = (i == 0); asi_eop = (i == 11);
      @(negedge clk);
      ev = (m > 0) && (pk > 0 || m == 10);
      checks++;
      if (v1 !== ev || rdy1 !== rdy || fl1 !== 4'(m)) begin
        errors++;
        $display("FAIL pkt12[%0d] got=%b/%b/%0d expected=%b/%b/%0d", c, v1, rdy1, fl1, ev, rdy, m);
      end
      push = (i < 12) && rdy;
      pop = ev;
      m = m + int'(push) - int'(pop);
      pk = pk + int'(push && i == 11) - int'(pop && o == 11);
      rdy = (m < 10);
      if (push) i++;
      if (pop) o++;
    end
    asi_valid = 1'b0;
    checks++;
    if (q1.size() != 0 || i != 12) begin
      errors++; $display("FAIL pkt12_done got=%0d left/%0d in expected=0/12", q1.size(), i);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    aso_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      next();
      asi_valid = 1'b1; asi_data = 8'(8'h50 + i); asi_sop = 1'b0; asi_eop = 1'b0;
    end
    next();
    asi_valid = 1'b0; reset = 1'b0;
    @(negedge clk);
    checks++;
    if (fl0 !== 4'd5) begin
      errors++; $display("FAIL midrst_pre got=%0d expected=5", fl0);
    end
    next();
    @(negedge clk);
    checks++;
    if (fl0 !== 4'd0 || v0 !== 1'b0 || rdy0 !== 1'b0) begin
      errors++; $display("FAIL midrst_clear got=%0d/%b/%b expected=0/0/0", fl0, v0, rdy0);
    end
    q0.delete();
    q1.delete();
    next();
    reset = 1'b1;
    next();
    asi_valid = 1'b1; asi_data = 8'hA5; asi_sop = 1'b1; asi_eop = 1'b1; aso_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b1) begin
      errors++; $display("FAIL midrst_ready got=%b expected=1", rdy0);
    end
    next();
    asi_valid = 1'b0; asi_sop = 1'b0; asi_eop = 1'b0;
    @(negedge clk);
    checks++;
    if (v0 !== 1'b1 || d0 !== 8'hA5 || fl0 !== 4'd1) begin
      errors++; $display("FAIL midrst_first got=%b/%h/%0d expected=1/a5/1", v0, d0, fl0);
    end
    next();
    @(negedge clk);
    checks++;
    if (v0 !== 1'b0 || q0.size() != 0) begin
      errors++; $display("FAIL midrst_empty got=%b/%0d expected=0/0", v0, q0.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_back_to_back();
    test_packet_short();
    test_packet_long();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
